// File: rtl/contador_pkg.sv
// contador_pkg: shared types, 7-segment constants and helper functions
// for the multiplexed BCD counter.
//   bcd_t      : one BCD digit (4 bits)
//   SEG_*      : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   bcd_to_seg : BCD digit -> active-high segment pattern
//   clamp_bcd  : saturate a nibble to the BCD range 0..9
package contador_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic bcd_t clamp_bcd(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD digit register of the counter chain.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load strobe (wins over stepping)
//   load_val_i   : digit to load, clamped to 9 if > 9
//   up_i         : 1 = increment, 0 = decrement
//   cin_i        : carry (up) / borrow (down) in; the digit steps when high
//   q_o          : current digit
//   cout_o       : carry/borrow out to the next digit (combinational)
module bcd_digit_cell
  import contador_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic [3:0] q_o,
  output logic       cout_o
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)
      q_d = clamp_bcd(load_val_i);
    else if (cin_i) begin
      if (up_i) q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      else      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  // Ripple out only when this digit rolls over in the current direction.
  assign cout_o = cin_i & (up_i ? (q_q == 4'd9) : (q_q == 4'd0));
  assign q_o    = q_q;

endmodule

// File: rtl/contador_bcd_multiplex.sv
// contador_bcd_multiplex: N-digit BCD up/down counter driving a
// time-multiplexed 7-segment bank.
//   clk, rst  : clock, synchronous active-high reset
//   en        : count enable (tick prescaler and counter hold when low)
//   up        : count direction, sampled on the step cycle
//   load      : synchronous load strobe, load_val digit 0 in [3:0]
//   count     : registered BCD count
//   seg, an   : registered segment bus {g,f,e,d,c,b,a} and digit enables
//   tick/wrap : registered one-cycle pulses on each step / on rollover
module contador_bcd_multiplex
  import contador_pkg::*;
#(
  parameter int CLK_FREQ   = 10000000,
  parameter int TICK_HZ    = 1,
  parameter int SCAN_HZ    = 1000,
  parameter int N_DIGITS   = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] count,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  tick,
  output logic                  wrap
);

  localparam int DIV_TICK = CLK_FREQ / TICK_HZ;
  localparam int DIV_SCAN = CLK_FREQ / (SCAN_HZ * N_DIGITS);
  localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int SW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV_TICK - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(DIV_SCAN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  localparam logic [6:0]          SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  if (DIV_TICK < 1) begin : g_bad_tick
    $error("DIV_TICK = CLK_FREQ/TICK_HZ must be >= 1");
  end
  if (DIV_SCAN < 1) begin : g_bad_scan
    $error("DIV_SCAN = CLK_FREQ/(SCAN_HZ*N_DIGITS) must be >= 1");
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_ndig
    $error("N_DIGITS must be in 1..8");
  end

  // ---------------- tick prescaler ----------------
  logic [TW-1:0] tpre_q, tpre_d;
  logic          step;

  // A load in the step cycle swallows the step entirely.
  assign step = en & (tpre_q == TICK_LAST) & ~load;

  always_comb begin
    tpre_d = tpre_q;
    if (load)
      tpre_d = '0;
    else if (en)
      tpre_d = (tpre_q == TICK_LAST) ? '0 : tpre_q + TW'(1);
  end

  // ---------------- digit chain ----------------
  logic [N_DIGITS-1:0][3:0] dig;
  logic [N_DIGITS:0]        carry;

  assign carry[0] = step;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    bcd_digit_cell u_dig (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .load_val_i (load_val[4*g +: 4]),
      .up_i       (up),
      .cin_i      (carry[g]),
      .q_o        (dig[g]),
      .cout_o     (carry[g+1])
    );
  end

  assign count = dig;

  // ---------------- scan ----------------
  logic [SW-1:0] spre_q, spre_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    spre_d = (spre_q == SCAN_LAST) ? '0 : spre_q + SW'(1);
    idx_d  = idx_q;
    if (spre_q == SCAN_LAST)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
  end

  // hz[k]: digits N_DIGITS-1..k are all zero.
  logic [N_DIGITS-1:0] hz;
  logic [3:0]          sel_dig;
  logic                sel_blank;
  logic [6:0]          seg_d;
  logic [N_DIGITS-1:0] an_d;

  always_comb begin
    hz[N_DIGITS-1] = (dig[N_DIGITS-1] == 4'd0);
    for (int k = N_DIGITS - 2; k >= 0; k--)
      hz[k] = hz[k+1] & (dig[k] == 4'd0);
  end

  always_comb begin
    sel_dig   = '0;
    sel_blank = 1'b0;
    an_d      = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_dig   = dig[k];
        sel_blank = (BLANK_LZ != 0) && (k > 0) && hz[k];
        an_d[k]   = 1'b1;
      end
    end
    seg_d = sel_blank ? SEG_BLANK : bcd_to_seg(sel_dig);
    if (ACTIVE_LOW != 0) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  // ---------------- registers ----------------
  logic [6:0]          seg_q;
  logic [N_DIGITS-1:0] an_q;
  logic                tick_q, wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tpre_q <= '0;
      spre_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tpre_q <= tpre_d;
      spre_q <= spre_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= step;
      wrap_q <= carry[N_DIGITS];  // already qualified by step through the chain
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_contador_bcd_multiplex.sv
// Self-checking bench: directed scenarios followed by random stimulus, all
// checked every cycle against a decimal-integer reference model.
module tb_contador_bcd_multiplex;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst, en, up, load;
  logic [15:0]   load_val;
  logic [15:0]   count;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          tick, wrap;

  int vectors = 0;
  int miscompares = 0;

  contador_bcd_multiplex #(
    .CLK_FREQ(100), .TICK_HZ(10), .SCAN_HZ(5),
    .N_DIGITS(ND), .ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .seg(seg), .an(an),
    .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_val;       // count as a plain decimal number 0..9999
  int          m_pre;       // enabled cycles since last step/load
  logic        m_tick, m_wrap;
  int          m_scan_t;    // non-reset edges since reset
  logic        m_disp_ok;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] lv);
    int r = 0;
    int d;
    for (int k = 0; k < ND; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      r = r + d * pow10(k);
    end
    return r;
  endfunction

  // Segment drawings {g,f,e,d,c,b,a}, lit = 1.
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  default: return 7'b1101111;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic ld, input logic [15:0] lv,
                            input logic e, input logic u);
    int idx;
    if (r) begin
      m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
      m_scan_t = 0; m_disp_ok = 0;
      m_seg = 7'h7f; m_an = 4'hf;
      return;
    end
    // Display shows the pre-edge count at the pre-edge scan position.
    idx = (m_scan_t / 5) % ND;
    m_an = ~(4'b1 << idx);
    if (idx > 0 && m_val < pow10(idx)) m_seg = 7'h7f;
    else                               m_seg = ~glyph((m_val / pow10(idx)) % 10);
    m_scan_t++;
    m_disp_ok = 1;
    m_tick = 0; m_wrap = 0;
    if (ld) begin
      m_val = load_to_int(lv);
      m_pre = 0;
    end else if (e) begin
      if (m_pre == 9) begin
        m_pre = 0;
        m_tick = 1;
        if (u) begin
          m_wrap = (m_val == 9999);
          m_val  = (m_val + 1) % 10000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 9999) % 10000;
        end
      end else m_pre++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [15:0] lv,
                     input logic e, input logic u);
    rst = r; load = ld; load_val = lv; en = e; up = u;
    @(posedge clk);
    model_edge(r, ld, lv, e, u);
    #1;
    chk("count", count, to_bcd(m_val));
    chk("tick", {15'b0, tick}, {15'b0, m_tick});
    chk("wrap", {15'b0, wrap}, {15'b0, m_wrap});
    chk("seg", {9'b0, seg}, {9'b0, m_seg});
    chk("an", {12'b0, an}, {12'b0, m_an});
  endtask

  task automatic run(input int n, input logic e, input logic u);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, e, u);
  endtask

  initial begin
    rst = 1; en = 0; up = 1; load = 0; load_val = '0;
    m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
    m_scan_t = 0; m_disp_ok = 0; m_seg = 7'h7f; m_an = 4'hf;

    // Reset state.
    cyc(1, 0, 16'h0, 0, 1);
    cyc(1, 0, 16'h0, 0, 1);

    // Count up 0..10.
    run(105, 1, 1);

    // Up wrap 9999 -> 0000.
    cyc(0, 1, 16'h9998, 1, 1);
    run(25, 1, 1);

    // Down wrap 0000 -> 9999.
    cyc(0, 1, 16'h0001, 1, 0);
    run(25, 1, 0);

    // Clamp of non-BCD nibbles.
    cyc(0, 1, 16'h3F5A, 0, 1);
    run(5, 0, 1);

    // Load on the step-due cycle drops the step.
    cyc(0, 1, 16'h0000, 1, 1);
    run(9, 1, 1);
    cyc(0, 1, 16'h0042, 1, 1);
    run(15, 1, 1);

    // Display scan with leading-zero blanking.
    cyc(0, 1, 16'h0305, 0, 1);
    run(45, 0, 1);

    // Enable dropped mid-period.
    cyc(0, 1, 16'h0000, 1, 1);
    run(4, 1, 1);
    run(7, 0, 1);
    run(12, 1, 1);

    // Reset mid-count.
    run(8, 1, 1);
    cyc(1, 0, 16'h0, 1, 1);
    run(15, 1, 1);

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      logic r, ld, e, u;
      logic [15:0] lv;
      r  = ($urandom_range(0, 399) == 0);
      ld = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 99) < 85);
      u  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        default: lv = 16'($urandom);
      endcase
      cyc(r, ld, lv, e, u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
